// File: rtl/noc_pkg.sv
// noc_pkg: definitions shared by the flit injector and the router side.
//   - head-flit field offsets/widths and the common destination width
//   - injector state enum
//   - helpers for length clamping and head-flit assembly
package noc_pkg;

   localparam int unsigned DEST_W   = 4;
   localparam int unsigned DEST_LSB = 0;
   localparam int unsigned SRC_LSB  = 4;
   localparam int unsigned LEN_LSB  = 8;
   localparam int unsigned SEQ_LSB  = 12;
   localparam int unsigned SEQ_W    = 16;
   localparam int unsigned HEAD_W   = 32;

   typedef enum logic [1:0] {IDLE, GAP, SEND} inj_state_e;

   // Requests shorter than head+tail or longer than the packet limit are clamped.
   function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
      if (len < 4'd2) return 4'd2;
      if (len > max_len) return max_len;
      return len;
   endfunction

   // Head flit: dest, source node, effective length, sequence number; upper nibble zero.
   function automatic logic [HEAD_W-1:0] make_head(input logic [DEST_W-1:0] dest,
                                                   input logic [3:0]        src,
                                                   input logic [3:0]        len,
                                                   input logic [SEQ_W-1:0]  seq);
      logic [HEAD_W-1:0] h;
      h = '0;
      h[DEST_LSB +: DEST_W] = dest;
      h[SRC_LSB +: 4]       = src;
      h[LEN_LSB +: 4]       = len;
      h[SEQ_LSB +: SEQ_W]   = seq;
      return h;
   endfunction

endpackage

// File: rtl/flit_gap_counter.sv
// flit_gap_counter: loadable down-counter that times the idle gap before a flit.
//   clk, rst : clock and synchronous active-high reset
//   load     : load 'value' into the counter this cycle
//   value    : gap length in cycles
//   expired  : high during the last gap cycle (count == 1)
// The counter stops at zero, so it stays quiet while the injector is sending.
module flit_gap_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] value,
   output logic             expired
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign expired = (count == WIDTH'(1));

endmodule

// File: rtl/noc_flit_injector.sv
// noc_flit_injector: turns one packet request into a head flit plus body flits
// with a programmable idle gap before every flit, and counts completed packets.
//   clk, rst                   : clock, synchronous active-high reset
//   req_valid/req_ready        : packet request handshake
//   req_dest, req_len          : destination node, total flits including head
//   req_base, req_gap          : payload base value, idle cycles before each flit
//   data_out/valid_out/ready_in: flit handshake toward the NoC node input port
//   busy                       : high whenever not idle
//   pkt_count                  : completed packets, wraps at 2^16
module noc_flit_injector
   import noc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NODE_ID    = 0,
   parameter int unsigned PKT_FLITS  = 6,
   parameter int unsigned GAP_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [DEST_W-1:0]     req_dest,
   input  logic [3:0]            req_len,
   input  logic [DATA_WIDTH-1:0] req_base,
   input  logic [GAP_WIDTH-1:0]  req_gap,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   input  logic                  ready_in,
   output logic                  busy,
   output logic [SEQ_W-1:0]      pkt_count
);

   inj_state_e            state;
   logic [DEST_W-1:0]     dest_r;
   logic [3:0]            len_r;
   logic [DATA_WIDTH-1:0] base_r;
   logic [GAP_WIDTH-1:0]  gap_r;
   logic [SEQ_W-1:0]      seq_r;
   logic [3:0]            index;

   logic [3:0]            acc_len;
   logic [DATA_WIDTH-1:0] acc_head;
   logic [DATA_WIDTH-1:0] cur_flit;
   logic                  last_flit;
   logic                  gap_load;
   logic [GAP_WIDTH-1:0]  gap_value;
   logic                  gap_expired;

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   // Head built straight from the request so it can be presented the cycle after accept.
   assign acc_len  = clamp_len(req_len, 4'(PKT_FLITS));
   assign acc_head = DATA_WIDTH'(make_head(req_dest, 4'(NODE_ID), acc_len, pkt_count));

   // Flit selected by the current index, used when leaving a gap.
   assign cur_flit = (index == 4'd0) ?
                     DATA_WIDTH'(make_head(dest_r, 4'(NODE_ID), len_r, seq_r)) :
                     base_r + DATA_WIDTH'(index);

   assign last_flit = (index == len_r - 4'd1);

   always_comb begin
      gap_load  = 1'b0;
      gap_value = gap_r;
      if (state == IDLE) begin
         gap_load  = req_valid && (req_gap != '0);
         gap_value = req_gap;
      end else if (state == SEND) begin
         gap_load  = ready_in && !last_flit && (gap_r != '0);
      end
   end

   flit_gap_counter #(
      .WIDTH (GAP_WIDTH)
   ) u_gap_counter (
      .clk     (clk),
      .rst     (rst),
      .load    (gap_load),
      .value   (gap_value),
      .expired (gap_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         valid_out <= 1'b0;
         data_out  <= '0;
         pkt_count <= '0;
         index     <= '0;
         dest_r    <= '0;
         len_r     <= 4'd2;
         base_r    <= '0;
         gap_r     <= '0;
         seq_r     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  dest_r <= req_dest;
                  len_r  <= acc_len;
                  base_r <= req_base;
                  gap_r  <= req_gap;
                  seq_r  <= pkt_count;
                  index  <= '0;
                  if (req_gap != '0) begin
                     state <= GAP;
                  end else begin
                     state     <= SEND;
                     valid_out <= 1'b1;
                     data_out  <= acc_head;
                  end
               end
            end
            GAP: begin
               if (gap_expired) begin
                  state     <= SEND;
                  valid_out <= 1'b1;
                  data_out  <= cur_flit;
               end
            end
            SEND: begin
               if (ready_in) begin
                  if (last_flit) begin
                     pkt_count <= pkt_count + 16'd1;
                     state     <= IDLE;
                     valid_out <= 1'b0;
                  end else begin
                     index <= index + 4'd1;
                     if (gap_r != '0) begin
                        state     <= GAP;
                        valid_out <= 1'b0;
                     end else begin
                        data_out <= base_r + DATA_WIDTH'(index) + DATA_WIDTH'(1);
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_noc_flit_injector.sv
// Scoreboard bench for noc_flit_injector: the driver pushes the expected flit
// sequence (value, idle cycles before it, tail marker) when a request is accepted;
// a negedge monitor pops and compares every flit handshake, checks gap lengths,
// stall stability, packet count and reset state.
module tb_noc_flit_injector;

   localparam int unsigned DW   = 32;
   localparam int unsigned NID  = 2;
   localparam int unsigned PKTF = 6;
   localparam int unsigned GW   = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [3:0]    req_dest = '0;
   logic [3:0]    req_len = '0;
   logic [DW-1:0] req_base = '0;
   logic [GW-1:0] req_gap = '0;
   logic [DW-1:0] data_out;
   logic          valid_out;
   logic          ready_in = 1'b1;
   logic          busy;
   logic [15:0]   pkt_count;

   always #5 clk = ~clk;

   noc_flit_injector #(
      .DATA_WIDTH (DW),
      .NODE_ID    (NID),
      .PKT_FLITS  (PKTF),
      .GAP_WIDTH  (GW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_dest  (req_dest),
      .req_len   (req_len),
      .req_base  (req_base),
      .req_gap   (req_gap),
      .data_out  (data_out),
      .valid_out (valid_out),
      .ready_in  (ready_in),
      .busy      (busy),
      .pkt_count (pkt_count)
   );

   typedef struct {
      logic [DW-1:0] data;
      int            gap;
      bit            tail;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] seq_mdl = '0;
   bit          rdy_rand = 1'b0;
   bit          rdy_force = 1'b1;

   // ---------------- monitor ----------------
   int          low_cnt = 0;
   bit          prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;
   bit          rst_seen = 1'b0;
   bit          after_tail = 1'b0;
   logic [15:0] cnt_mdl = '0;
   exp_t        mon_e;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (rst_seen) begin
            check("rst_valid", 64'(valid_out), 64'(0));
            check("rst_data", 64'(data_out), 64'(0));
            check("rst_count", 64'(pkt_count), 64'(0));
            check("rst_req_ready", 64'(req_ready), 64'(1));
            check("rst_busy", 64'(busy), 64'(0));
         end
         rst_seen   = 1'b1;
         low_cnt    = 0;
         prev_stall = 1'b0;
         after_tail = 1'b0;
         cnt_mdl    = '0;
      end else begin
         rst_seen = 1'b0;
         check("pkt_count", 64'(pkt_count), 64'(cnt_mdl));
         check("busy_vs_ready", 64'(busy), 64'(!req_ready));
         // Exactly one bubble: the cycle after a tail must be idle.
         if (after_tail) begin
            check("idle_after_tail", 64'(req_ready), 64'(1));
            check("valid_after_tail", 64'(valid_out), 64'(0));
         end
         after_tail = 1'b0;
         if (valid_out) begin
            check("req_ready_in_send", 64'(req_ready), 64'(0));
            if (prev_stall) begin
               check("stall_hold", 64'(data_out), 64'(prev_data));
            end else if (sb.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_flit: got 0x%0h required none at %0t", data_out, $time);
            end else begin
               check("gap_cycles", 64'(low_cnt), 64'(sb[0].gap));
            end
            low_cnt = 0;
            if (ready_in && sb.size() != 0) begin
               mon_e = sb.pop_front();
               check("flit_data", 64'(data_out), 64'(mon_e.data));
               if (mon_e.tail) begin
                  cnt_mdl++;
                  after_tail = 1'b1;
               end
            end
            prev_stall = !ready_in;
            prev_data  = data_out;
         end else begin
            if (prev_stall) check("valid_withdrawn", 64'(valid_out), 64'(1));
            prev_stall = 1'b0;
            low_cnt++;
         end
         if (req_valid && req_ready) low_cnt = 0;
      end
   end

   // ---------------- driver ----------------
   task automatic step();
      @(posedge clk);
      #1;
      ready_in = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
   endtask

   task automatic send_req(input logic [3:0] dest, input logic [3:0] len,
                           input logic [DW-1:0] base, input logic [GW-1:0] gap);
      int   eff;
      int   guard;
      exp_t e;
      req_dest  = dest;
      req_len   = len;
      req_base  = base;
      req_gap   = gap;
      req_valid = 1'b1;
      guard     = 0;
      while (1) begin
         @(negedge clk);
         if (req_ready) break;
         guard++;
         if (guard > 5000) begin
            $display("FAIL accept_timeout: got no accept required accept within 5000 cycles");
            $fatal(1);
         end
         step();
      end
      eff = (int'(len) < 2) ? 2 : ((int'(len) > int'(PKTF)) ? int'(PKTF) : int'(len));
      e.data = 32'(dest) + (32'(NID) << 4) + (32'(eff) << 8) + (32'(seq_mdl) << 12);
      e.gap  = int'(gap);
      e.tail = 1'b0;
      sb.push_back(e);
      for (int k = 1; k < eff; k++) begin
         e.data = base + 32'(k);
         e.gap  = int'(gap);
         e.tail = (k == eff - 1);
         sb.push_back(e);
      end
      seq_mdl++;
      step();
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (sb.size() != 0) begin
         guard++;
         if (guard > 20000) begin
            $display("FAIL drain_timeout: got %0d flits pending required 0", sb.size());
            $fatal(1);
         end
         step();
      end
      step();
      step();
   endtask

   initial begin
      int guard;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();

      // Gap 0, ready always high: 0x625, 0x101..0x105.
      rdy_force = 1'b1;
      send_req(4'd5, 4'd6, 32'h100, 8'd0);
      drain();

      // Gap 3: same flits, 3 idle cycles before each.
      send_req(4'd5, 4'd6, 32'h100, 8'd3);
      drain();

      // Backpressure: ready low for 4 cycles while 0x102 is presented.
      send_req(4'd5, 4'd6, 32'h100, 8'd0);
      guard = 0;
      while (1) begin
         @(negedge clk);
         if (valid_out && data_out == 32'h101 && ready_in) break;
         guard++;
         if (guard > 100) begin
            $display("FAIL bp_timeout: got no 0x101 flit required one");
            $fatal(1);
         end
         step();
      end
      rdy_force = 1'b0;
      step();
      step();
      step();
      step();
      rdy_force = 1'b1;
      step();
      drain();

      // Length clamps (second one also wraps the payload).
      send_req(4'd3, 4'd1, 32'h200, 8'd0);
      send_req(4'd7, 4'd12, 32'hFFFF_FFFE, 8'd1);
      drain();

      // Back-to-back requests, second held valid.
      send_req(4'd1, 4'd3, 32'h10, 8'd0);
      send_req(4'd2, 4'd4, 32'h20, 8'd0);
      drain();

      // Gap boundaries: maximum gap and gap of 1.
      send_req(4'd4, 4'd2, 32'h0, 8'd255);
      send_req(4'd4, 4'd3, 32'h5, 8'd1);
      drain();

      // Randomized traffic with random backpressure.
      rdy_rand = 1'b1;
      for (int i = 0; i < 24; i++) begin
         send_req(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom,
                  8'($urandom_range(0, 4)));
         if ($urandom_range(0, 2) == 0) drain();
      end
      drain();
      rdy_rand  = 1'b0;
      rdy_force = 1'b1;
      step();

      // Reset mid-packet after flit 3 of 6; restart begins at seq 0.
      send_req(4'd9, 4'd6, 32'h300, 8'd0);
      guard = 0;
      while (sb.size() != 3) begin
         guard++;
         if (guard > 100) begin
            $display("FAIL mid_reset_timeout: got %0d pending required 3", sb.size());
            $fatal(1);
         end
         step();
      end
      rst = 1'b1;
      sb.delete();
      seq_mdl = '0;
      step();
      step();
      rst = 1'b0;
      step();
      send_req(4'd9, 4'd6, 32'h300, 8'd2);
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
